// File: rtl/timerio_if.sv
// timerio_if: cpu68 (6801) peripheral bus bundle for one I/O responder.
//   cs  - chip select (address decode AND vma), driven by the CPU side
//   rw  - 1 = read, 0 = write
//   AD  - register select
//   DI  - write data from the CPU
//   DO  - read data back to the CPU
// The CPU side uses the master modport. The peripheral uses the slave modport.
interface timerio_if;
    logic       cs;
    logic       rw;
    logic [2:0] AD;
    logic [7:0] DI;
    logic [7:0] DO;

    modport master (
        output cs,
        output rw,
        output AD,
        output DI,
        input  DO
    );

    modport slave (
        input  cs,
        input  rw,
        input  AD,
        input  DI,
        output DO
    );
endinterface

// File: rtl/timerio.sv
// timerio: memory-mapped 16-bit down-counting timer on the cpu68 peripheral bus.
// It has an 8-bit prescaler and a sticky overflow flag with an interrupt enable.
//   clk - sys_clk. All state changes happen on its rising edge.
//   rst - synchronous, active-high reset
//   bus - slave side of the peripheral bus (cs/rw/AD/DI/DO)
//   irq - level interrupt, OVF & IE
// Register map (AD):
//   0 CTRL  {EN, PERIODIC, IE} in b0..b2
//   1 STAT  b0 OVF (write 1 to clear), b1 RUN
//   2 PRESC
//   3 RELH
//   4 RELL
//   5 CNTH  live count high byte. A read also latches the low byte into the shadow.
//   6 CNTL  the latched shadow
//   7 reads 0
module timerio #(
    parameter logic [15:0] RESET_RELOAD   = 16'hFFFF,
    parameter logic [7:0]  RESET_PRESCALE = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    timerio_if.slave    bus,
    output logic        irq
);

    localparam logic [2:0] AddrCtrl  = 3'd0;
    localparam logic [2:0] AddrStat  = 3'd1;
    localparam logic [2:0] AddrPresc = 3'd2;
    localparam logic [2:0] AddrRelH  = 3'd3;
    localparam logic [2:0] AddrRelL  = 3'd4;
    localparam logic [2:0] AddrCntH  = 3'd5;
    localparam logic [2:0] AddrCntL  = 3'd6;

    logic        en_q, en_d;
    logic        per_q, per_d;
    logic        ie_q, ie_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  presc_q, presc_d;
    logic [7:0]  pcnt_q, pcnt_d;
    logic [15:0] reload_q, reload_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  shadow_q, shadow_d;

    logic wr, rd;
    logic wr_ctrl, wr_stat, wr_presc, wr_relh, wr_rell;
    logic rd_cnth;
    logic tick, expire, start;

    // Bus strobes
    always_comb begin
        wr       = bus.cs & ~bus.rw;
        rd       = bus.cs & bus.rw;
        wr_ctrl  = wr && (bus.AD == AddrCtrl);
        wr_stat  = wr && (bus.AD == AddrStat);
        wr_presc = wr && (bus.AD == AddrPresc);
        wr_relh  = wr && (bus.AD == AddrRelH);
        wr_rell  = wr && (bus.AD == AddrRelL);
        rd_cnth  = rd && (bus.AD == AddrCntH);
    end

    // The tick and expiry use pre-edge state. A CTRL write on the same edge
    // changes only what happens after that edge.
    always_comb begin
        tick   = en_q && (pcnt_q == presc_q);
        expire = tick && (count_q == 16'h0000);
        // EN can only rise while stopped, so a start never coincides with a tick.
        start  = wr_ctrl && bus.DI[0] && !en_q;
    end

    // Next-state logic
    always_comb begin
        en_d     = en_q;
        per_d    = per_q;
        ie_d     = ie_q;
        ovf_d    = ovf_q;
        presc_d  = presc_q;
        pcnt_d   = pcnt_q;
        reload_d = reload_q;
        count_d  = count_q;
        shadow_d = shadow_q;

        // Prescaler: wraps after PRESC, giving a tick every PRESC+1 clocks
        if (en_q) begin
            pcnt_d = tick ? 8'h00 : pcnt_q + 8'h01;
        end
        if (start || wr_presc) begin
            pcnt_d = 8'h00;
        end

        // Counter
        if (tick) begin
            if (count_q != 16'h0000) begin
                count_d = count_q - 16'h0001;
            end else if (per_q) begin
                count_d = reload_q;
            end else begin
                count_d = 16'h0000;
            end
        end
        if (start) begin
            count_d = reload_q;
        end

        // One-shot expiry stops the timer. An explicit CTRL write on the same
        // edge takes precedence.
        if (expire && !per_q) begin
            en_d = 1'b0;
        end
        if (wr_ctrl) begin
            en_d  = bus.DI[0];
            per_d = bus.DI[1];
            ie_d  = bus.DI[2];
        end

        // If an expiry and a write-1-clear land on the same edge, the set wins.
        if (wr_stat && bus.DI[0]) begin
            ovf_d = 1'b0;
        end
        if (expire) begin
            ovf_d = 1'b1;
        end

        if (wr_presc) begin
            presc_d = bus.DI;
        end
        if (wr_relh) begin
            reload_d[15:8] = bus.DI;
        end
        if (wr_rell) begin
            reload_d[7:0] = bus.DI;
        end

        // Latch the low byte as the high byte is read, so CNTH then CNTL is coherent.
        if (rd_cnth) begin
            shadow_d = count_q[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q     <= 1'b0;
            per_q    <= 1'b0;
            ie_q     <= 1'b0;
            ovf_q    <= 1'b0;
            presc_q  <= RESET_PRESCALE;
            pcnt_q   <= 8'h00;
            reload_q <= RESET_RELOAD;
            count_q  <= 16'h0000;
            shadow_q <= 8'h00;
        end else begin
            en_q     <= en_d;
            per_q    <= per_d;
            ie_q     <= ie_d;
            ovf_q    <= ovf_d;
            presc_q  <= presc_d;
            pcnt_q   <= pcnt_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            shadow_q <= shadow_d;
        end
    end

    // Read mux. It depends only on AD and register state, not on cs.
    always_comb begin
        bus.DO = 8'h00;
        case (bus.AD)
            AddrCtrl:  bus.DO = {5'b00000, ie_q, per_q, en_q};
            AddrStat:  bus.DO = {6'b000000, en_q, ovf_q};
            AddrPresc: bus.DO = presc_q;
            AddrRelH:  bus.DO = reload_q[15:8];
            AddrRelL:  bus.DO = reload_q[7:0];
            AddrCntH:  bus.DO = count_q[15:8];
            AddrCntL:  bus.DO = shadow_q;
            default:   bus.DO = 8'h00;
        endcase
    end

    assign irq = ovf_q & ie_q;

endmodule
